id_hazard_controller: RTL and testbench

Sequencing controller for the instruction-decode stage. Each cycle it decides whether the PC and IF/ID register advance, stall or flush. It drives `mux_ctrl_signal_sel` on the decode stage, so a stall injects an all-zero control bubble into ID/EX. It runs a small stall FSM with a down-counter for multi-cycle hazards, and keeps saturating stall and flush statistics.

---
 rtl/id_hazard_controller.sv | 162 ++++++++++++++++
 tb/tb_id_hazard_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_controller.sv
// ---------------------------------------------------------------------------
// id_hazard_controller
//
// Decode-stage sequencing controller. Every cycle it decides whether the PC
// and IF/ID register advance, stall or flush, and selects between decoded
// control and an all-zero bubble for ID/EX. A two-state stall FSM with a
// down-counter covers hazards that need more than one stall cycle.
// Saturating counters record stalled cycles and flushes.
//
// Ports
//   clock, reset            : clock, asynchronous active-high reset
//   id_rs, id_rt            : source register fields of the instruction in ID
//   id_uses_rs, id_uses_rt  : the ID instruction reads that source
//   id_is_branch            : ID holds a conditional branch resolved in ID
//   branch_taken            : decode-stage branch decision
//   ex_rd/ex_reg_write/ex_mem_read    : destination and flags of EX instr
//   mem_rd/mem_reg_write/mem_mem_read : destination and flags of MEM instr
//   ext_stall               : front-end freeze request
//   pc_write, if_id_write   : PC / IF/ID load enables
//   if_id_flush             : IF/ID clears to NOP on the next edge
//   mux_ctrl_signal_sel     : 1 = decoded control, 0 = bubble
//   stall_cycles            : saturating count of stalled cycles
//   flush_count             : saturating count of flushes
//   busy                    : FSM is in STALL
// ---------------------------------------------------------------------------
module id_hazard_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             branch_taken,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic             ext_stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             mux_ctrl_signal_sel,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             busy
);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_STALL = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_remain;
  logic [1:0] w_remain_nxt;
  logic [1:0] w_remain_dec;
  logic [1:0] w_need;
  logic       w_ex_match;
  logic       w_mem_match;

  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  function automatic logic src_match(input logic [4:0] x,
                                     input logic [4:0] rs, input logic use_rs,
                                     input logic [4:0] rt, input logic use_rt);
    return (x != 5'd0) && ((use_rs && (x == rs)) || (use_rt && (x == rt)));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  assign w_ex_match  = src_match(ex_rd,  id_rs, id_uses_rs, id_rt, id_uses_rt);
  assign w_mem_match = src_match(mem_rd, id_rs, id_uses_rs, id_rt, id_uses_rt);
  assign w_remain_dec = r_remain - 2'd1;

  // Stall cycles still needed before ID can proceed. A load in EX feeding a
  // branch needs two (the value exists only after MEM); every other listed
  // case needs one. The load-in-EX rule already dominates the others.
  always_comb begin
    w_need = 2'd0;
    if (ex_mem_read && ex_reg_write && w_ex_match)
      w_need = id_is_branch ? 2'd2 : 2'd1;
    else if (id_is_branch &&
             ((ex_reg_write && !ex_mem_read && w_ex_match) ||
              (mem_mem_read && mem_reg_write && w_mem_match)))
      w_need = 2'd1;
  end

  // Outputs and next state. Priority: reset, external freeze, STALL, RUN.
  // A hazard wins over a taken branch; the branch is re-evaluated later.
  always_comb begin
    pc_write            = 1'b1;
    if_id_write         = 1'b1;
    if_id_flush         = 1'b0;
    mux_ctrl_signal_sel = 1'b1;
    w_state_nxt         = r_state;
    w_remain_nxt        = r_remain;
    if (reset) begin
      pc_write            = 1'b0;
      if_id_write         = 1'b0;
      mux_ctrl_signal_sel = 1'b0;
    end else if (ext_stall) begin
      // Freeze: stall pattern, FSM and remain hold.
      pc_write            = 1'b0;
      if_id_write         = 1'b0;
      mux_ctrl_signal_sel = 1'b0;
    end else if (r_state == S_STALL) begin
      pc_write            = 1'b0;
      if_id_write         = 1'b0;
      mux_ctrl_signal_sel = 1'b0;
      w_remain_nxt        = w_remain_dec;
      if (w_remain_dec == 2'd0)
        w_state_nxt = S_RUN;
    end else if (w_need != 2'd0) begin
      pc_write            = 1'b0;
      if_id_write         = 1'b0;
      mux_ctrl_signal_sel = 1'b0;
      if (w_need == 2'd2) begin
        w_state_nxt  = S_STALL;
        w_remain_nxt = 2'd1;
      end
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_RUN;
      r_remain <= 2'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_remain <= w_remain_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!pc_write)
        r_stall_cycles <= sat_inc(r_stall_cycles);
      if (if_id_flush)
        r_flush_count <= sat_inc(r_flush_count);
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
  assign busy         = (r_state == S_STALL);

endmodule

// File: tb/tb_id_hazard_controller.sv
// Scoreboard bench: the driver applies one directed vector per cycle and
// pushes the hand-computed expected outputs; a monitor pops and compares on
// the falling edge.
module tb_id_hazard_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
  logic        id_uses_rs, id_uses_rt, id_is_branch, branch_taken;
  logic        ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read, ext_stall;

  logic        pc_write, if_id_write, if_id_flush, mux_sel, busy;
  logic [15:0] stall_cycles, flush_count;
  logic        pc_write4, if_id_write4, if_id_flush4, mux_sel4, busy4;
  logic [3:0]  stall_cycles4, flush_count4;

  always #5 clock = ~clock;

  id_hazard_controller #(.CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .branch_taken(branch_taken),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .ext_stall(ext_stall),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .mux_ctrl_signal_sel(mux_sel), .stall_cycles(stall_cycles),
    .flush_count(flush_count), .busy(busy)
  );

  id_hazard_controller #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .branch_taken(branch_taken),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .ext_stall(ext_stall),
    .pc_write(pc_write4), .if_id_write(if_id_write4), .if_id_flush(if_id_flush4),
    .mux_ctrl_signal_sel(mux_sel4), .stall_cycles(stall_cycles4),
    .flush_count(flush_count4), .busy(busy4)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs, rt;
    logic       urs, urt, br, bt;
    logic [4:0] exrd;
    logic       exrw, exmr;
    logic [4:0] memrd;
    logic       memrw, memmr;
    logic       ext;
  } stim_t;

  typedef struct packed {
    logic [31:0] tag;
    logic [4:0]  ctl;   // {pc_write, if_id_write, if_id_flush, mux_sel, busy}
    logic [15:0] sc;
    logic [15:0] fc;
    logic        chk4;
    logic [3:0]  f4;
  } exp_t;

  localparam logic [4:0] RUNV = 5'b11010;
  localparam logic [4:0] FLV  = 5'b11110;
  localparam logic [4:0] STL  = 5'b00000;
  localparam logic [4:0] STB  = 5'b00001;
  localparam logic [4:0] ZRO  = 5'b00000;

  exp_t  sb[$];
  stim_t nxt;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    step_no = 0;

  task automatic apply(input stim_t s);
    reset        = s.rst;
    id_rs        = s.rs;    id_rt        = s.rt;
    id_uses_rs   = s.urs;   id_uses_rt   = s.urt;
    id_is_branch = s.br;    branch_taken = s.bt;
    ex_rd        = s.exrd;  ex_reg_write = s.exrw;  ex_mem_read  = s.exmr;
    mem_rd       = s.memrd; mem_reg_write = s.memrw; mem_mem_read = s.memmr;
    ext_stall    = s.ext;
  endtask

  task automatic issue(input logic [4:0] ctl, input int sc, input int fc,
                       input bit chk4 = 1'b0, input int f4 = 0);
    exp_t e;
    @(posedge clock);
    #1;
    apply(nxt);
    e.tag  = step_no;
    e.ctl  = ctl;
    e.sc   = 16'(sc);
    e.fc   = 16'(fc);
    e.chk4 = chk4;
    e.f4   = 4'(f4);
    sb.push_back(e);
    step_no++;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Monitor
  initial begin
    exp_t       e;
    logic [4:0] act;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {pc_write, if_id_write, if_id_flush, mux_sel, busy};
        n_cmp++;
        if (act !== e.ctl || stall_cycles !== e.sc || flush_count !== e.fc) begin
          n_bad++;
          $display("FAIL step%0d outputs: got ctl=%b sc=%0d fc=%0d, want ctl=%b sc=%0d fc=%0d",
                   e.tag, act, stall_cycles, flush_count, e.ctl, e.sc, e.fc);
        end
        if (e.chk4) begin
          n_cmp++;
          if (flush_count4 !== e.f4) begin
            n_bad++;
            $display("FAIL step%0d flush_count_w4: got %0d, want %0d",
                     e.tag, flush_count4, e.f4);
          end
        end
      end
    end
  end

  // Driver
  initial begin
    apply(idle());
    reset = 1'b1;

    // Reset cycle
    nxt = idle(); nxt.rst = 1'b1;
    issue(ZRO, 0, 0);

    // lw r3 in EX, add reads r3 -> one stall
    nxt = idle(); nxt.rs = 5'd3; nxt.rt = 5'd4; nxt.urs = 1; nxt.urt = 1;
    nxt.exrd = 5'd3; nxt.exrw = 1; nxt.exmr = 1;
    issue(STL, 0, 0);
    nxt = idle(); nxt.rs = 5'd3; nxt.rt = 5'd4; nxt.urs = 1; nxt.urt = 1;
    nxt.memrd = 5'd3; nxt.memrw = 1; nxt.memmr = 1;
    issue(RUNV, 1, 0);
    nxt = idle();
    issue(RUNV, 1, 0);

    // Producer writing r0 with ID reading r0 -> no stall
    nxt = idle(); nxt.urs = 1; nxt.urt = 1; nxt.exrw = 1; nxt.exmr = 1;
    issue(RUNV, 1, 0);
    nxt.br = 1;
    issue(RUNV, 1, 0);

    // lw r5 in EX, beq r5,r0 taken -> two stalls then flush
    nxt = idle(); nxt.rst = 1'b1;
    issue(ZRO, 0, 0);
    nxt = idle(); nxt.rs = 5'd5; nxt.urs = 1; nxt.urt = 1; nxt.br = 1; nxt.bt = 1;
    nxt.exrd = 5'd5; nxt.exrw = 1; nxt.exmr = 1;
    issue(STL, 0, 0);
    nxt.exrd = 5'd0; nxt.exrw = 0; nxt.exmr = 0;
    nxt.memrd = 5'd5; nxt.memrw = 1; nxt.memmr = 1;
    issue(STB, 1, 0);
    nxt.memrd = 5'd0; nxt.memrw = 0; nxt.memmr = 0;
    issue(FLV, 2, 0);
    nxt = idle();
    issue(RUNV, 2, 1);

    // ext_stall for 3 cycles during STALL with remain=1
    nxt = idle(); nxt.rst = 1'b1;
    issue(ZRO, 0, 0);
    nxt = idle(); nxt.rs = 5'd5; nxt.urs = 1; nxt.br = 1; nxt.bt = 1;
    nxt.exrd = 5'd5; nxt.exrw = 1; nxt.exmr = 1;
    issue(STL, 0, 0);
    nxt.exrd = 5'd0; nxt.exrw = 0; nxt.exmr = 0; nxt.ext = 1;
    issue(STB, 1, 0);
    issue(STB, 2, 0);
    issue(STB, 3, 0);
    nxt.ext = 0;
    issue(STB, 4, 0);
    nxt = idle();
    issue(RUNV, 5, 0);

    // ext_stall in RUN suppresses a taken-branch flush
    nxt = idle(); nxt.br = 1; nxt.bt = 1; nxt.ext = 1;
    issue(STL, 5, 0);
    nxt = idle();
    issue(RUNV, 6, 0);

    // ALU result in EX feeding a branch -> one stall, then flush
    nxt = idle(); nxt.rs = 5'd7; nxt.urs = 1; nxt.br = 1; nxt.bt = 1;
    nxt.exrd = 5'd7; nxt.exrw = 1;
    issue(STL, 6, 0);
    nxt.exrd = 5'd0; nxt.exrw = 0; nxt.memrd = 5'd7; nxt.memrw = 1;
    issue(FLV, 7, 0);
    nxt = idle();
    issue(RUNV, 7, 1);

    // Load in MEM feeding a branch (via rt) -> one stall
    nxt = idle(); nxt.rt = 5'd9; nxt.urt = 1; nxt.br = 1;
    nxt.memrd = 5'd9; nxt.memrw = 1; nxt.memmr = 1;
    issue(STL, 7, 1);
    nxt = idle();
    issue(RUNV, 8, 1);
    // Same load in MEM, non-branch consumer -> forwarded, no stall
    nxt = idle(); nxt.rt = 5'd9; nxt.urt = 1;
    nxt.memrd = 5'd9; nxt.memrw = 1; nxt.memmr = 1;
    issue(RUNV, 8, 1);
    // Matching field but source not read -> no stall
    nxt = idle(); nxt.rs = 5'd3; nxt.exrd = 5'd3; nxt.exrw = 1; nxt.exmr = 1;
    issue(RUNV, 8, 1);

    // Reset asserted while in STALL
    nxt = idle(); nxt.rst = 1'b1;
    issue(ZRO, 0, 0);
    nxt = idle(); nxt.rs = 5'd5; nxt.urs = 1; nxt.br = 1; nxt.bt = 1;
    nxt.exrd = 5'd5; nxt.exrw = 1; nxt.exmr = 1;
    issue(STL, 0, 0);
    nxt.rst = 1'b1;
    issue(ZRO, 0, 0);
    nxt = idle(); nxt.rs = 5'd5; nxt.urs = 1; nxt.br = 1; nxt.bt = 1;
    issue(FLV, 0, 0);
    nxt = idle();
    issue(RUNV, 0, 1);

    // 20 taken branches: 16-bit count keeps going, 4-bit count saturates
    nxt = idle(); nxt.rst = 1'b1;
    issue(ZRO, 0, 0, 1'b1, 0);
    nxt = idle(); nxt.br = 1; nxt.bt = 1;
    for (int k = 0; k < 20; k++)
      issue(FLV, 0, k, 1'b1, (k > 15) ? 15 : k);
    nxt = idle();
    issue(RUNV, 0, 20, 1'b1, 15);

    repeat (3) @(posedge clock);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
